// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: flush sweep > pending invalidate > buffered taken-branch updates.
// Optional BTB_UPD_COALESCE_EN: a same-index push overwrites the most recently queued entry.
module btb_update_ctrl #(
  parameter int DEPTH   = 4,
  parameter int ENTRIES = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [31:0]                    upd_pc,
  input  logic [31:0]                    upd_target,
  input  logic                           inv_en,
  input  logic [31:0]                    inv_pc,
  input  logic                           flush_req,
  output logic                           flush_busy,
  output logic                           flush_done,
  output logic                           btb_we,
  output logic [31:0]                    btb_pc,
  output logic [31:0]                    btb_target,
  output logic                           btb_valid,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IDX = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [31:0]    fifo_pc  [DEPTH];
  logic [31:0]    fifo_tgt [DEPTH];
  logic [PW:0]    wptr, rptr;
  logic           inv_pend;
  logic [31:0]    inv_pc_q;
  logic [IDX:0]   sweep_cnt, sweep_nxt;
  logic           done_nxt;

  logic           pop, push, alloc, coal;
  logic           inv_sel, inv_set, inv_pend_nxt, work_nxt;

  logic           sel_we_p0, sel_valid_p0;
  logic [31:0]    sel_pc_p0, sel_tgt_p0;

  assign fifo_count = wptr - rptr;
  assign flush_busy = (state == FLUSH);

  assign pop     = (state != FLUSH) && !flush_req && !inv_pend && (fifo_count != '0);
  assign inv_sel = (state != FLUSH) && !flush_req && inv_pend;
  assign inv_set = inv_en && (state != FLUSH) && !flush_req;

`ifdef BTB_UPD_COALESCE_EN
  logic [PW-1:0] tail;
  assign tail = wptr[PW-1:0] - PW'(1);
  // The tail is the last pushed entry; it may only absorb a push if it is not leaving this cycle.
  assign coal = (fifo_count != '0) && (upd_pc[IDX+1:2] == fifo_pc[tail][IDX+1:2]) &&
                !(pop && (fifo_count == CW'(1)));
`else
  assign coal = 1'b0;
`endif

  assign upd_ready    = (state != FLUSH) && !flush_req && ((fifo_count < CW'(DEPTH)) || coal);
  assign push         = upd_valid && upd_ready;
  assign alloc        = push && !coal;
  assign inv_pend_nxt = inv_set || (inv_pend && !inv_sel && !flush_req);
  assign work_nxt     = inv_pend_nxt || alloc || (fifo_count > CW'(pop));

  // Stage p0: select at most one write for the port
  always_comb begin
    state_nxt    = state;
    sweep_nxt    = sweep_cnt;
    done_nxt     = 1'b0;
    sel_we_p0    = 1'b0;
    sel_pc_p0    = btb_pc;
    sel_tgt_p0   = btb_target;
    sel_valid_p0 = btb_valid;
    if (flush_req) begin
      state_nxt    = FLUSH;
      sel_we_p0    = 1'b1;
      sel_pc_p0    = '0;
      sel_tgt_p0   = '0;
      sel_valid_p0 = 1'b0;
      sweep_nxt    = (IDX+1)'(1);
    end else if (state == FLUSH) begin
      if (sweep_cnt == (IDX+1)'(ENTRIES)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        sweep_nxt = '0;
      end else begin
        sel_we_p0    = 1'b1;
        sel_pc_p0    = {{(30-IDX){1'b0}}, sweep_cnt[IDX-1:0], 2'b00};
        sel_tgt_p0   = '0;
        sel_valid_p0 = 1'b0;
        sweep_nxt    = sweep_cnt + (IDX+1)'(1);
      end
    end else begin
      if (inv_sel) begin
        sel_we_p0    = 1'b1;
        sel_pc_p0    = inv_pc_q;
        sel_tgt_p0   = '0;
        sel_valid_p0 = 1'b0;
      end else if (pop) begin
        sel_we_p0    = 1'b1;
        sel_pc_p0    = fifo_pc[rptr[PW-1:0]];
        sel_tgt_p0   = fifo_tgt[rptr[PW-1:0]];
        sel_valid_p0 = 1'b1;
      end
      state_nxt = work_nxt ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p1: registered write port and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      inv_pend   <= 1'b0;
      sweep_cnt  <= '0;
      flush_done <= 1'b0;
      btb_we     <= 1'b0;
      btb_pc     <= '0;
      btb_target <= '0;
      btb_valid  <= 1'b0;
    end else begin
      sweep_cnt  <= sweep_nxt;
      flush_done <= done_nxt;
      inv_pend   <= inv_pend_nxt;
      btb_we     <= sel_we_p0;
      btb_pc     <= sel_pc_p0;
      btb_target <= sel_tgt_p0;
      btb_valid  <= sel_valid_p0;
      if (flush_req) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (alloc) wptr <= wptr + (PW+1)'(1);
        if (pop)   rptr <= rptr + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inv_set) inv_pc_q <= inv_pc;
    if (alloc) begin
      fifo_pc[wptr[PW-1:0]]  <= upd_pc;
      fifo_tgt[wptr[PW-1:0]] <= upd_target;
    end
`ifdef BTB_UPD_COALESCE_EN
    else if (push) begin
      fifo_pc[tail]  <= upd_pc;
      fifo_tgt[tail] <= upd_target;
    end
`endif
  end

endmodule
